fifo_axis_reader: RTL and testbench



---
 rtl/fifo_axis_reader_pkg.sv | 14 +
 rtl/axis_out_buf.sv | 50 +++++
 rtl/fifo_axis_reader.sv | 77 +++++++
 tb/tb_fifo_axis_reader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_axis_reader_pkg.sv
// Shared sizing and pointer helpers for the FIFO-to-AXIS reader.
package fifo_axis_reader_pkg;

  localparam int BUF_DEPTH = 3;
  localparam int RD_LAT    = 1;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] occ_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/axis_out_buf.sv
// 3-entry circular output buffer; push lands next cycle, head is a direct register read.
// No internal backpressure: the caller must never push into a full buffer without a pop.
module axis_out_buf
  import fifo_axis_reader_pkg::*;
#(
  parameter int B = 160
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [B-1:0] push_data,
  input  logic         pop,
  output logic [B-1:0] head_data,
  output occ_t         occ
);

  logic [B-1:0] mem [BUF_DEPTH];
  ptr_t         head;
  ptr_t         tail;
  logic         pop_ok;

  assign pop_ok    = pop && (occ != '0);
  assign head_data = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_inc(tail);
      end
      if (pop_ok) head <= ptr_inc(head);
      case ({push, pop_ok})
        2'b10:   occ <= occ_t'(occ + 2'd1);
        2'b01:   occ <= occ_t'(occ - 2'd1);
        default: occ <= occ;
      endcase
    end
  end

  // A push into a full buffer with no simultaneous pop would overwrite the head.
  always @(posedge clk) begin
    if (!rst) assert (!(push && !pop_ok && (occ == occ_t'(BUF_DEPTH))));
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a latency-1 FIFO read port into an AXI4-Stream master; first beat 2 cycles after empty falls.
// Reads are throttled by buffer occupancy only, never by m_axis_tready; up to 3 words held under stall.
module fifo_axis_reader
  import fifo_axis_reader_pkg::*;
#(
  parameter int B       = 160,
  parameter int PKT_LEN = 0,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             fifo_rd_en,
  input  logic [B-1:0]     fifo_dout,
  input  logic             fifo_empty,
  output logic [B-1:0]     m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PKT_W-1:0] PKT_LAST = (PKT_LEN > 0) ? PKT_W'(PKT_LEN - 1) : '0;

  logic       inflight;
  occ_t       occ;
  logic       pop;
  logic [2:0] pending;

  // Occupancy plus the word already requested bounds the next read, so no tready path exists.
  assign pending       = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en    = !rst && en && !fifo_empty && (pending < 3'(BUF_DEPTH));
  assign m_axis_tvalid = (occ != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;

  axis_out_buf #(.B(B)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .head_data (m_axis_tdata),
    .occ       (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  if (PKT_LEN > 0) begin : g_pkt
    logic [PKT_W-1:0] pkt_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pkt_cnt <= '0;
      end else if (pop) begin
        pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + PKT_W'(1);
      end
    end

    assign m_axis_tlast = m_axis_tvalid && (pkt_cnt == PKT_LAST);
  end else begin : g_nopkt
    assign m_axis_tlast = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst) assert (pending <= 3'(BUF_DEPTH));
  end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench: behavioural FIFO + scoreboard, a cycle table for latency/stall, and directed corner sequences.
module tb_fifo_axis_reader;

  localparam int B    = 160;
  localparam int B2   = 37;
  localparam int CNT2 = 16;
  localparam int PKT  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            tready = 1'b0;
  logic            wr_en = 1'b0;
  logic [B-1:0]    wr_dat = '0;
  logic            fifo_rd_en;
  logic            fifo_empty = 1'b1;
  logic [B-1:0]    fifo_dout = '0;
  logic [B-1:0]    tdata;
  logic            tvalid, tlast;
  logic [31:0]     beat_cnt;
  logic            rd_en2, tvalid2, tlast2;
  logic [B2-1:0]   tdata2;
  logic [CNT2-1:0] beat_cnt2;

  always #5 clk = ~clk;

  fifo_axis_reader #(.B(B), .PKT_LEN(PKT), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .en(en), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .beat_cnt(beat_cnt)
  );

  fifo_axis_reader #(.B(B2), .PKT_LEN(0), .CNT_W(CNT2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .fifo_rd_en(rd_en2), .fifo_dout(fifo_dout[B2-1:0]),
    .fifo_empty(fifo_empty), .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(tready), .m_axis_tlast(tlast2), .beat_cnt(beat_cnt2)
  );

  int           total = 0;
  int           bad = 0;
  int           acc = 0;
  int           rd_pulses = 0;
  logic [11:0]  tl_mask = '0;
  logic [B-1:0] fq[$];
  logic [B-1:0] exp_q[$];
  logic         prev_v = 1'b0;
  logic         prev_r = 1'b0;
  logic [B-1:0] prev_d = '0;

  task automatic chk(input string nm, input logic [B-1:0] got, input logic [B-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Behavioural read-latency-1 FIFO; reset together with the DUT.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (wr_en) fq.push_back(wr_dat);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Scoreboard: every accepted beat must be the oldest written word not yet delivered.
  always @(negedge clk) begin
    logic [B-1:0] e;
    if (!rst) begin
      if (fifo_rd_en) rd_pulses++;
      if (prev_v && !prev_r) begin
        chk("hold_valid", B'(tvalid), B'(1));
        chk("hold_data", tdata, prev_d);
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          fail("beat_without_expected_word");
        end else begin
          e = exp_q.pop_front();
          chk("data", tdata, e);
          chk("beat_cnt", B'(beat_cnt), B'(acc));
          chk("tlast", B'(tlast), B'((acc % PKT) == PKT - 1));
          chk("dut2_valid", B'(tvalid2), B'(1));
          chk("dut2_data", B'(tdata2), B'(e[B2-1:0]));
          chk("dut2_tlast", B'(tlast2), B'(0));
          chk("dut2_beat_cnt", B'(beat_cnt2), B'(CNT2'(acc)));
          if (tlast && acc < 12) tl_mask[acc] = 1'b1;
        end
        acc++;
      end
      prev_v = tvalid;
      prev_r = tready;
      prev_d = tdata;
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_wr(input logic w, input logic [B-1:0] d);
    wr_en  = w;
    wr_dat = d;
    if (w) exp_q.push_back(d);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    wr_en = 1'b0;
    exp_q.delete();
    acc = 0;
    tl_mask = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_reads(input int n);
    int k;
    k = 0;
    while (rd_pulses < n && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (rd_pulses < n) fail("wait_reads_timeout");
  endtask

  task automatic wait_drain(input string nm, input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      step();
      k++;
    end
    chk(nm, B'(exp_q.size()), B'(0));
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rdy;
    logic       e_rd;
    logic       e_v;
    logic [7:0] e_d;
    int         e_bc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int k;
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 2};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3};

    // Reset state, observed while rst is held.
    #12;
    chk("rst_rd_en", B'(fifo_rd_en), B'(0));
    chk("rst_tvalid", B'(tvalid), B'(0));
    chk("rst_tdata", tdata, '0);
    chk("rst_tlast", B'(tlast), B'(0));
    chk("rst_beat_cnt", B'(beat_cnt), B'(0));
    do_reset();

    // Cycle table: single-word latency, then a two-word stall and release.
    en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      drv_wr(tbl[i].wr, B'(tbl[i].d));
      tready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd_en", i), B'(fifo_rd_en), B'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_tvalid", i), B'(tvalid), B'(tbl[i].e_v));
      if (tbl[i].e_v) chk($sformatf("tbl%0d_tdata", i), tdata, B'(tbl[i].e_d));
      chk($sformatf("tbl%0d_beat_cnt", i), B'(beat_cnt), B'(tbl[i].e_bc));
    end

    // Full-rate burst from a preloaded FIFO.
    do_reset();
    en = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drv_wr(1'b1, B'(i));
      step();
    end
    drv_wr(1'b0, '0);
    repeat (2) step();
    en = 1'b1;
    @(negedge clk);
    k = 0;
    while (!tvalid && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!tvalid) fail("burst_start_timeout");
    for (int i = 0; i < 16; i++) begin
      chk("burst_valid", B'(tvalid), B'(1));
      chk("burst_data", tdata, B'(i));
      @(negedge clk);
    end
    chk("burst_cnt", B'(beat_cnt), B'(16));
    chk("burst_end_valid", B'(tvalid), B'(0));

    // Backpressure: exactly three reads then stall with word 0 held.
    do_reset();
    en = 1'b0;
    tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drv_wr(1'b1, B'(100 + i));
      step();
    end
    drv_wr(1'b0, '0);
    repeat (2) step();
    rd_pulses = 0;
    en = 1'b1;
    repeat (20) step();
    chk("bp_reads", B'(rd_pulses), B'(3));
    @(negedge clk);
    chk("bp_head", tdata, B'(100));
    step();
    tready = 1'b1;
    wait_drain("bp_drained", 40);

    // Packet framing over 12 beats.
    do_reset();
    en = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drv_wr(1'b1, B'(200 + i));
      step();
    end
    drv_wr(1'b0, '0);
    wait_drain("pkt_drained", 40);
    repeat (2) step();
    chk("pkt_mask", B'(tl_mask), B'(12'b1000_1000_1000));

    // en dropped after five reads.
    do_reset();
    en = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv_wr(1'b1, B'(300 + i));
      step();
    end
    drv_wr(1'b0, '0);
    repeat (2) step();
    rd_pulses = 0;
    en = 1'b1;
    wait_reads(5);
    step();
    en = 1'b0;
    repeat (10) step();
    chk("en_reads", B'(rd_pulses), B'(5));
    chk("en_beats", B'(acc), B'(5));

    // Two more words buffered under stall, then asynchronous reset.
    tready = 1'b0;
    en = 1'b1;
    wait_reads(7);
    step();
    en = 1'b0;
    repeat (3) step();
    chk("pre_rst_valid", B'(tvalid), B'(1));
    chk("pre_rst_cnt", B'(beat_cnt), B'(5));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", B'(tvalid), B'(0));
    chk("async_rst_cnt", B'(beat_cnt), B'(0));
    exp_q.delete();
    acc = 0;
    repeat (2) step();
    rst = 1'b0;
    step();
    en = 1'b1;
    tready = 1'b1;
    drv_wr(1'b1, B'(8'h3C));
    step();
    drv_wr(1'b0, '0);
    wait_drain("post_rst_drained", 20);
    repeat (2) step();
    chk("post_rst_beats", B'(acc), B'(1));

    // Random traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      step();
      drv_wr($urandom_range(0, 9) < 5,
             {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      tready = ($urandom_range(0, 9) < 7);
      en = ($urandom_range(0, 19) != 0);
    end
    step();
    drv_wr(1'b0, '0);
    en = 1'b1;
    tready = 1'b1;
    wait_drain("rand_drained", 200);
    if (acc < 1000) fail("rand_too_few_beats");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
